// File: rtl/oc_button.sv
// rtl/oc_button.sv - debounced button inputs with press/release events, press counters and CSR access
// Optional feature macro: OC_BUTTON_IRQ_EN adds the registered level interrupt and per-button irqEnable.
package oc_button_pkg;
  typedef struct packed {
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
  } csr_32_s;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
  } csr_32_fb_s;

  localparam logic [15:0] CsrIdButton = 16'hB077;
endpackage

module oc_button #(
  parameter int  ClockHz     = 100_000_000,
  parameter int  ButtonCount = 1,
  parameter type CsrType     = oc_button_pkg::csr_32_s,
  parameter type CsrFbType   = oc_button_pkg::csr_32_fb_s,
  parameter int  SyncCycles  = 3,
  localparam int ButtonCountSafe = (ButtonCount > 0) ? ButtonCount : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  CsrType                     csr,
  output CsrFbType                   csrFb,
  input  logic [ButtonCountSafe-1:0] buttonIn,
  output logic [ButtonCountSafe-1:0] buttonLevel,
  output logic                       irq
);
  localparam int PrescaleRaw = ClockHz / 1000 - 1;
  localparam logic [15:0] PrescaleInit = (PrescaleRaw > 65535) ? 16'hFFFF :
                                         (PrescaleRaw < 0)     ? 16'd0   : 16'(PrescaleRaw);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] resetPipe;
  logic       rstN;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) resetPipe <= 2'b00;
    else        resetPipe <= {resetPipe[0], 1'b1};
  end
  assign rstN = resetPipe[1];

  logic [15:0]                prescale;
  logic [3:0]                 debounceTicks;
  logic [ButtonCountSafe-1:0] invert;
  logic [ButtonCountSafe-1:0] pressSticky;
  logic [ButtonCountSafe-1:0] releaseSticky;
  logic [7:0]                 pressCount [ButtonCountSafe];
  logic [3:0]                 dbCnt [ButtonCountSafe];
  logic [ButtonCountSafe-1:0] syncStage [SyncCycles];
  logic [ButtonCountSafe-1:0] syncIn;
  logic [ButtonCountSafe-1:0] commit;
  logic [ButtonCountSafe-1:0] regSel;
  logic [15:0]                tickCnt;
  logic                       tick;
  logic [3:0]                 ticksNeeded;
  logic                       csrAccess;
  logic                       csrWrite;
  logic [31:0]                rdata;
  logic                       unusedPwdata;
`ifdef OC_BUTTON_IRQ_EN
  logic [ButtonCountSafe-1:0] irqEnable;
`endif

  assign csrAccess    = csr.psel & csr.penable & rstN;
  assign csrWrite     = csrAccess & csr.pwrite;
  assign unusedPwdata = ^csr.pwdata[31:20];

  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < SyncCycles; k++) syncStage[k] <= '0;
    end else begin
      syncStage[0] <= buttonIn ^ invert;
      for (int k = 1; k < SyncCycles; k++) syncStage[k] <= syncStage[k-1];
    end
  end
  assign syncIn = syncStage[SyncCycles-1];

  // >= rather than == so a prescale written below the running count still ticks promptly.
  assign tick = (tickCnt >= prescale);
  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN)     tickCnt <= 16'd0;
    else if (tick) tickCnt <= 16'd0;
    else           tickCnt <= tickCnt + 16'd1;
  end

  assign ticksNeeded = (debounceTicks == 4'd0) ? 4'd1 : debounceTicks;

  always_comb begin
    commit = '0;
    regSel = '0;
    for (int i = 0; i < ButtonCountSafe; i++) begin
      commit[i] = (syncIn[i] != buttonLevel[i]) && tick &&
                  (({1'b0, dbCnt[i]} + 5'd1) >= {1'b0, ticksNeeded});
      regSel[i] = csrWrite && (csr.paddr == 8'(i + 2));
    end
  end

  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      buttonLevel   <= '0;
      pressSticky   <= '0;
      releaseSticky <= '0;
      invert        <= '0;
      for (int i = 0; i < ButtonCountSafe; i++) begin
        dbCnt[i]      <= 4'd0;
        pressCount[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < ButtonCountSafe; i++) begin
        if (syncIn[i] == buttonLevel[i])  dbCnt[i] <= 4'd0;
        else if (commit[i])               dbCnt[i] <= 4'd0;
        else if (tick)                    dbCnt[i] <= dbCnt[i] + 4'd1;
        if (commit[i]) buttonLevel[i] <= syncIn[i];
        if (commit[i] && syncIn[i]) pressCount[i] <= pressCount[i] + 8'd1;
        // A new event in the same cycle as a clear leaves the bit set.
        pressSticky[i]   <= (pressSticky[i]   & ~(regSel[i] & csr.pwdata[1])) | (commit[i] &  syncIn[i]);
        releaseSticky[i] <= (releaseSticky[i] & ~(regSel[i] & csr.pwdata[2])) | (commit[i] & ~syncIn[i]);
        if (regSel[i]) invert[i] <= csr.pwdata[16];
      end
    end
  end

  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      prescale      <= PrescaleInit;
      debounceTicks <= 4'd10;
    end else if (csrWrite && csr.paddr == 8'd1) begin
      prescale      <= csr.pwdata[15:0];
      debounceTicks <= csr.pwdata[19:16];
    end
  end

`ifdef OC_BUTTON_IRQ_EN
  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      irqEnable <= '0;
      irq       <= 1'b0;
    end else begin
      for (int i = 0; i < ButtonCountSafe; i++)
        if (regSel[i]) irqEnable[i] <= csr.pwdata[17];
      irq <= |(irqEnable & (pressSticky | releaseSticky));
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = 32'd0;
    if (csr.paddr == 8'd0) begin
      rdata = {oc_button_pkg::CsrIdButton, 8'd0, 8'(ButtonCount)};
    end else if (csr.paddr == 8'd1) begin
      rdata = {12'd0, debounceTicks, prescale};
    end else begin
      for (int i = 0; i < ButtonCountSafe; i++) begin
        if (csr.paddr == 8'(i + 2)) begin
`ifdef OC_BUTTON_IRQ_EN
          rdata = {14'd0, irqEnable[i], invert[i], pressCount[i], 5'd0,
                   releaseSticky[i], pressSticky[i], buttonLevel[i]};
`else
          rdata = {14'd0, 1'b0, invert[i], pressCount[i], 5'd0,
                   releaseSticky[i], pressSticky[i], buttonLevel[i]};
`endif
        end
      end
    end
  end

  always_comb begin
    csrFb        = '0;
    csrFb.pready = csrAccess;
    csrFb.prdata = (csrAccess && !csr.pwrite) ? rdata : 32'd0;
  end
endmodule
